// File: rtl/bin_slot_alloc.sv
// Slot allocator: busy bitmap with one registered grant per cycle and release by
// binary index. Contains bin2oht_tree, the binary-to-one-hot decoder it shares with downstream logic.

module bin2oht_tree #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 2
) (
    input  logic                     vld,
    input  logic [$clog2(WIDTH)-1:0] bin,
    output logic [WIDTH-1:0]         oht
);
    localparam int W_LOG = $clog2(WIDTH);
    localparam int HI_W  = $clog2(SPLIT);
    localparam int LO_W  = W_LOG - HI_W;
    localparam int GROUP = WIDTH / SPLIT;

    // Two-level decode: the upper bits select one of SPLIT groups, the lower bits
    // select the entry inside the group, and the two one-hots are ANDed.
    logic [SPLIT-1:0] hi_oht;

    for (genvar g = 0; g < SPLIT; g++) begin : g_hi
        assign hi_oht[g] = vld && (bin[W_LOG-1 -: HI_W] == HI_W'(g));
    end

    if (LO_W == 0) begin : g_flat
        assign oht = hi_oht;
    end else begin : g_tree
        logic [GROUP-1:0] lo_oht;
        for (genvar l = 0; l < GROUP; l++) begin : g_lo
            assign lo_oht[l] = (bin[LO_W-1:0] == LO_W'(l));
        end
        for (genvar g = 0; g < SPLIT; g++) begin : g_grp
            for (genvar l = 0; l < GROUP; l++) begin : g_ent
                assign oht[g*GROUP+l] = hi_oht[g] & lo_oht[l];
            end
        end
    end
endmodule

module bin_slot_alloc #(
    parameter int WIDTH  = 32,
    parameter int SPLIT  = 2,
    parameter int POLICY = 0,
    localparam int WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_req,
    output logic                 alloc_rdy,
    output logic                 alloc_vld,
    output logic [WIDTH_LOG-1:0] alloc_bin,
    input  logic                 free_vld,
    input  logic [WIDTH_LOG-1:0] free_bin,
    output logic [WIDTH-1:0]     busy,
    output logic [WIDTH_LOG:0]   cnt,
    output logic                 err
);
    localparam int CNT_W = WIDTH_LOG + 1;

    logic [WIDTH-1:0]     busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 alloc_vld_q, alloc_vld_d;
    logic [WIDTH_LOG-1:0] alloc_bin_q, alloc_bin_d;
    logic [WIDTH_LOG-1:0] ptr_q, ptr_d;
    logic                 err_q, err_d;

    logic [WIDTH_LOG-1:0] base;
    logic [WIDTH_LOG-1:0] idx;
    logic [WIDTH_LOG-1:0] sel_bin;
    logic                 found;
    logic                 grant;
    logic                 free_ok;
    logic [WIDTH-1:0]     set_mask;
    logic [WIDTH-1:0]     free_mask;

    assign alloc_rdy = |(~busy_q);
    assign grant     = alloc_req && alloc_rdy;
    assign free_ok   = free_vld && busy_q[free_bin];

    // Lowest-index policy is the round-robin search anchored at WIDTH-1, so both
    // share one scan; the anchor itself is the last candidate visited.
    always_comb begin
        base    = (POLICY == 1) ? ptr_q : {WIDTH_LOG{1'b1}};
        idx     = '0;
        sel_bin = '0;
        found   = 1'b0;
        for (int k = 1; k <= WIDTH; k++) begin
            idx = base + WIDTH_LOG'(k);
            if (!found && !busy_q[idx]) begin
                sel_bin = idx;
                found   = 1'b1;
            end
        end
    end

    bin2oht_tree #(
        .WIDTH (WIDTH),
        .SPLIT (SPLIT)
    ) u_free_dec (
        .vld (free_vld),
        .bin (free_bin),
        .oht (free_mask)
    );

    assign set_mask = grant ? (WIDTH'(1) << sel_bin) : '0;

    // A grant only picks a clear bit and a release only matters on a set bit, so
    // the two masks never collide and the freed slot waits a cycle to be eligible.
    always_comb begin
        busy_d      = (busy_q & ~free_mask) | set_mask;
        alloc_vld_d = grant;
        alloc_bin_d = grant ? sel_bin : alloc_bin_q;
        ptr_d       = grant ? sel_bin : ptr_q;
        err_d       = err_q | (free_vld && !busy_q[free_bin]);
        cnt_d       = cnt_q;
        case ({grant, free_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            cnt_q       <= '0;
            alloc_vld_q <= 1'b0;
            alloc_bin_q <= '0;
            ptr_q       <= {WIDTH_LOG{1'b1}};
            err_q       <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            alloc_vld_q <= alloc_vld_d;
            alloc_bin_q <= alloc_bin_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
        end
    end

    assign busy      = busy_q;
    assign cnt       = cnt_q;
    assign alloc_vld = alloc_vld_q;
    assign alloc_bin = alloc_bin_q;
    assign err       = err_q;
endmodule

// File: tb/tb_bin_slot_alloc.sv
// Directed bench for bin_slot_alloc: an 8-slot lowest-index instance (u0) and an
// 8-slot round-robin instance (u1) sharing clock and reset.

module tb_bin_slot_alloc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       req0 = 1'b0, fv0 = 1'b0;
    logic [2:0] fb0 = '0;
    logic       rdy0, vld0, err0;
    logic [2:0] bin0;
    logic [7:0] busy0;
    logic [3:0] cnt0;

    logic       req1 = 1'b0, fv1 = 1'b0;
    logic [2:0] fb1 = '0;
    logic       rdy1, vld1, err1;
    logic [2:0] bin1;
    logic [7:0] busy1;
    logic [3:0] cnt1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bin_slot_alloc #(.WIDTH(8), .SPLIT(2), .POLICY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .alloc_req(req0), .alloc_rdy(rdy0),
        .alloc_vld(vld0), .alloc_bin(bin0), .free_vld(fv0), .free_bin(fb0),
        .busy(busy0), .cnt(cnt0), .err(err0)
    );

    bin_slot_alloc #(.WIDTH(8), .SPLIT(2), .POLICY(1)) u1 (
        .clk(clk), .rst_n(rst_n), .alloc_req(req1), .alloc_rdy(rdy1),
        .alloc_vld(vld1), .alloc_bin(bin1), .free_vld(fv1), .free_bin(fb1),
        .busy(busy1), .cnt(cnt1), .err(err1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({busy0, cnt0, vld0, bin0, err0, rdy0} !== {8'h00, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_u0 got busy=%h cnt=%0d vld=%b bin=%0d err=%b rdy=%b exp busy=00 cnt=0 vld=0 bin=0 err=0 rdy=1",
                     busy0, cnt0, vld0, bin0, err0, rdy0);
        end
        tests_run++;
        if ({busy1, cnt1, vld1, err1, rdy1} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_u1 got busy=%h cnt=%0d vld=%b err=%b rdy=%b", busy1, cnt1, vld1, err1, rdy1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if ({vld0, bin0, cnt0} !== {1'b1, 3'(i), 4'(i + 1)}) begin
                tests_failed++;
                $display("FAIL fill_grant%0d got vld=%b bin=%0d cnt=%0d exp vld=1 bin=%0d cnt=%0d",
                         i, vld0, bin0, cnt0, i, i + 1);
            end
        end
        tests_run++;
        if ({busy0, rdy0} !== {8'hFF, 1'b0}) begin
            tests_failed++;
            $display("FAIL fill_full got busy=%h rdy=%b exp busy=ff rdy=0", busy0, rdy0);
        end
        tick();
        tests_run++;
        if ({vld0, bin0, cnt0, busy0} !== {1'b0, 3'd7, 4'd8, 8'hFF}) begin
            tests_failed++;
            $display("FAIL full_ignore got vld=%b bin=%0d cnt=%0d busy=%h exp vld=0 bin=7 cnt=8 busy=ff",
                     vld0, bin0, cnt0, busy0);
        end
        req0 = 1'b0;
    endtask

    task automatic test_free_regrant();
        fv0 = 1'b1;
        fb0 = 3'd3;
        tick();
        fv0 = 1'b0;
        tests_run++;
        if ({rdy0, busy0, cnt0, vld0} !== {1'b1, 8'hF7, 4'd7, 1'b0}) begin
            tests_failed++;
            $display("FAIL free3 got rdy=%b busy=%h cnt=%0d vld=%b exp rdy=1 busy=f7 cnt=7 vld=0",
                     rdy0, busy0, cnt0, vld0);
        end
        req0 = 1'b1;
        tick();
        req0 = 1'b0;
        tests_run++;
        if ({vld0, bin0, cnt0, busy0} !== {1'b1, 3'd3, 4'd8, 8'hFF}) begin
            tests_failed++;
            $display("FAIL regrant3 got vld=%b bin=%0d cnt=%0d busy=%h exp vld=1 bin=3 cnt=8 busy=ff",
                     vld0, bin0, cnt0, busy0);
        end
    endtask

    task automatic test_simul_full();
        req0 = 1'b1;
        fv0  = 1'b1;
        fb0  = 3'd5;
        tick();
        fv0 = 1'b0;
        tests_run++;
        if ({vld0, busy0, cnt0} !== {1'b0, 8'hDF, 4'd7}) begin
            tests_failed++;
            $display("FAIL simul_full got vld=%b busy=%h cnt=%0d exp vld=0 busy=df cnt=7", vld0, busy0, cnt0);
        end
        tick();
        req0 = 1'b0;
        tests_run++;
        if ({vld0, bin0, cnt0, busy0} !== {1'b1, 3'd5, 4'd8, 8'hFF}) begin
            tests_failed++;
            $display("FAIL simul_next got vld=%b bin=%0d cnt=%0d busy=%h exp vld=1 bin=5 cnt=8 busy=ff",
                     vld0, bin0, cnt0, busy0);
        end
    endtask

    task automatic test_err();
        fv0 = 1'b1;
        fb0 = 3'd6;
        tick();
        tests_run++;
        if ({err0, busy0, cnt0} !== {1'b0, 8'hBF, 4'd7}) begin
            tests_failed++;
            $display("FAIL free6 got err=%b busy=%h cnt=%0d exp err=0 busy=bf cnt=7", err0, busy0, cnt0);
        end
        tick();
        fv0 = 1'b0;
        tests_run++;
        if ({err0, busy0, cnt0} !== {1'b1, 8'hBF, 4'd7}) begin
            tests_failed++;
            $display("FAIL double_free got err=%b busy=%h cnt=%0d exp err=1 busy=bf cnt=7", err0, busy0, cnt0);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (err0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky got err=%b exp err=1", err0);
        end
        // grant and valid release together: count holds, freed slot 0 not picked
        req0 = 1'b1;
        fv0  = 1'b1;
        fb0  = 3'd0;
        tick();
        fv0 = 1'b0;
        tests_run++;
        if ({vld0, bin0, busy0, cnt0} !== {1'b1, 3'd6, 8'hFE, 4'd7}) begin
            tests_failed++;
            $display("FAIL simul_grant got vld=%b bin=%0d busy=%h cnt=%0d exp vld=1 bin=6 busy=fe cnt=7",
                     vld0, bin0, busy0, cnt0);
        end
        tick();
        req0 = 1'b0;
        tests_run++;
        if ({vld0, bin0, cnt0, err0} !== {1'b1, 3'd0, 4'd8, 1'b1}) begin
            tests_failed++;
            $display("FAIL grant_after_free0 got vld=%b bin=%0d cnt=%0d err=%b exp vld=1 bin=0 cnt=8 err=1",
                     vld0, bin0, cnt0, err0);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rr [8] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0};
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({vld1, bin1} !== {1'b1, 3'(i)}) begin
                tests_failed++;
                $display("FAIL rr_first%0d got vld=%b bin=%0d exp vld=1 bin=%0d", i, vld1, bin1, i);
            end
        end
        req1 = 1'b0;
        fv1  = 1'b1;
        fb1  = 3'd0;
        tick();
        fv1 = 1'b0;
        tests_run++;
        if ({busy1, cnt1} !== {8'h06, 4'd2}) begin
            tests_failed++;
            $display("FAIL rr_free0 got busy=%h cnt=%0d exp busy=06 cnt=2", busy1, cnt1);
        end
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests_run++;
            if ({vld1, bin1} !== {1'b1, exp_rr[i]}) begin
                tests_failed++;
                $display("FAIL rr_seq%0d got vld=%b bin=%0d exp vld=1 bin=%0d", i, vld1, bin1, exp_rr[i]);
            end
        end
        req1 = 1'b0;
        tests_run++;
        if ({busy1, cnt1, rdy1} !== {8'hFF, 4'd8, 1'b0}) begin
            tests_failed++;
            $display("FAIL rr_full got busy=%h cnt=%0d rdy=%b exp busy=ff cnt=8 rdy=0", busy1, cnt1, rdy1);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        tick();
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy0, cnt0, vld0} !== {8'h00, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_rst_u0 got busy=%h cnt=%0d vld=%b exp busy=00 cnt=0 vld=0", busy0, cnt0, vld0);
        end
        tests_run++;
        if ({busy1, cnt1, vld1} !== {8'h00, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_rst_u1 got busy=%h cnt=%0d vld=%b exp busy=00 cnt=0 vld=0", busy1, cnt1, vld1);
        end
        #1;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({vld0, bin0, vld1, bin1} !== {1'b1, 3'd0, 1'b1, 3'd0}) begin
            tests_failed++;
            $display("FAIL post_rst_grant got vld0=%b bin0=%0d vld1=%b bin1=%0d exp 1 0 1 0",
                     vld0, bin0, vld1, bin1);
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_fill();
        test_free_regrant();
        test_simul_full();
        test_err();
        test_round_robin();
        test_async_reset();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
